// File: rtl/decode_queue.sv
// decode_queue: RV32 decode stage feeding a small in-order FIFO.
// Instructions are decoded combinationally on entry and stored with their
// decoded fields. The head entry is presented from registered storage and
// masked to zero whenever the queue is empty.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_B = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_imm,
  output logic [4:0]                 out_waddr,
  output logic [4:0]                 out_raddr1,
  output logic [4:0]                 out_raddr2,
  output logic                       out_wren,
  output logic                       out_rden1,
  output logic                       out_rden2,
  output logic [3:0]                 out_class,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CLS_ILLEGAL = 4'd0;
  localparam logic [3:0] CLS_ALU     = 4'd1;
  localparam logic [3:0] CLS_LUI     = 4'd2;
  localparam logic [3:0] CLS_AUIPC   = 4'd3;
  localparam logic [3:0] CLS_JAL     = 4'd4;
  localparam logic [3:0] CLS_JALR    = 4'd5;
  localparam logic [3:0] CLS_BRANCH  = 4'd6;
  localparam logic [3:0] CLS_LOAD    = 4'd7;
  localparam logic [3:0] CLS_STORE   = 4'd8;
  localparam logic [3:0] CLS_MUL     = 4'd9;
  localparam logic [3:0] CLS_DIV     = 4'd10;
  localparam logic [3:0] CLS_BITM    = 4'd11;
  localparam logic [3:0] CLS_FENCE   = 4'd12;
  localparam logic [3:0] CLS_CSR     = 4'd13;
  localparam logic [3:0] CLS_PRIV    = 4'd14;
  localparam logic [3:0] CLS_NOP     = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wren;
    logic        rden1;
    logic        rden2;
    logic [3:0]  cls;
    logic        illegal;
  } entry_t;

  // Pointer advance with explicit wrap at the last slot.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [3:0]  cls;
  logic        use_rs1;
  logic        use_rs2;
  logic        zb_imm_f1;
  logic        zb_imm_f5;
  logic        zb_op;
  logic        zext_h;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  entry_t      entry_d;
  entry_t      shown;
  entry_t      mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq;
  logic          deq;

  // Instruction classification and register-use flags from the raw word.
  always_comb begin
    opcode  = in_instr[6:0];
    funct3  = in_instr[14:12];
    funct7  = in_instr[31:25];
    rd      = in_instr[11:7];
    rs1     = in_instr[19:15];
    rs2     = in_instr[24:20];
    cls     = CLS_ILLEGAL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;

    zb_imm_f1 = ((funct7 == 7'b0110000) && (rs2 inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd5}))
              || (funct7 inside {7'b0010100, 7'b0100100, 7'b0110100});
    zb_imm_f5 = (funct7 == 7'b0110000) || (funct7 == 7'b0100100)
              || (in_instr[31:20] == 12'h287) || (in_instr[31:20] == 12'h698);
    zext_h    = (funct7 == 7'b0000100) && (funct3 == 3'd4) && (rs2 == 5'd0);

    case (funct7)
      7'b0010000:             zb_op = funct3 inside {3'd2, 3'd4, 3'd6};
      7'b0100000:             zb_op = funct3 inside {3'd4, 3'd6, 3'd7};
      7'b0000101:             zb_op = (funct3 != 3'd0);
      7'b0000100:             zb_op = zext_h;
      7'b0110000, 7'b0100100: zb_op = funct3 inside {3'd1, 3'd5};
      7'b0010100, 7'b0110100: zb_op = (funct3 == 3'd1);
      default:                zb_op = 1'b0;
    endcase

    case (opcode)
      OPC_LUI:   cls = CLS_LUI;
      OPC_AUIPC: cls = CLS_AUIPC;
      OPC_JAL:   cls = CLS_JAL;
      OPC_JALR: begin
        if (funct3 == 3'd0) begin
          cls     = CLS_JALR;
          use_rs1 = 1'b1;
        end else begin
          cls = CLS_ILLEGAL;
        end
      end
      OPC_BRANCH: begin
        if ((funct3 != 3'd2) && (funct3 != 3'd3)) begin
          cls     = CLS_BRANCH;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end else begin
          cls = CLS_ILLEGAL;
        end
      end
      OPC_LOAD: begin
        if (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
          cls     = CLS_LOAD;
          use_rs1 = 1'b1;
        end else begin
          cls = CLS_ILLEGAL;
        end
      end
      OPC_STORE: begin
        if (funct3 <= 3'd2) begin
          cls     = CLS_STORE;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end else begin
          cls = CLS_ILLEGAL;
        end
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'd1: begin
            if (funct7 == 7'b0000000)       cls = CLS_ALU;
            else if (ENABLE_B && zb_imm_f1) cls = CLS_BITM;
            else                            cls = CLS_ILLEGAL;
          end
          3'd5: begin
            if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) cls = CLS_ALU;
            else if (ENABLE_B && zb_imm_f5)                       cls = CLS_BITM;
            else                                                  cls = CLS_ILLEGAL;
          end
          // The canonical nop (addi x0,x0,0) gets its own class.
          default: cls = (in_instr == 32'h0000_0013) ? CLS_NOP : CLS_ALU;
        endcase
        use_rs1 = (cls != CLS_ILLEGAL);
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000)                                      cls = CLS_ALU;
        else if ((funct7 == 7'b0100000) && (funct3 inside {3'd0, 3'd5})) cls = CLS_ALU;
        else if ((funct7 == 7'b0000001) && ENABLE_M)                   cls = funct3[2] ? CLS_DIV : CLS_MUL;
        else if (ENABLE_B && zb_op)                                    cls = CLS_BITM;
        else                                                           cls = CLS_ILLEGAL;
        use_rs1 = (cls != CLS_ILLEGAL);
        // zext.h is encoded as an R-type with rs2 fixed to x0 and reads only rs1.
        use_rs2 = (cls != CLS_ILLEGAL) && !zext_h;
      end
      OPC_MISC: begin
        if (funct3 inside {3'd0, 3'd1}) cls = CLS_FENCE;
        else                            cls = CLS_ILLEGAL;
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'd0: begin
            if (in_instr[31:20] inside {12'h000, 12'h001, 12'h302, 12'h105}) cls = CLS_PRIV;
            else                                                             cls = CLS_ILLEGAL;
          end
          3'd4: cls = CLS_ILLEGAL;
          3'd1, 3'd2, 3'd3: begin
            cls     = CLS_CSR;
            use_rs1 = 1'b1;
          end
          // csrrwi/csrrsi/csrrci carry a 5-bit immediate in the rs1 field.
          default: cls = CLS_CSR;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  // Immediate formats of the incoming word.
  always_comb begin
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'd0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  end

  // Assemble the entry to be stored: immediate, enables and gated register addresses.
  always_comb begin
    entry_d         = '0;
    entry_d.pc      = in_pc;
    entry_d.instr   = in_instr;
    entry_d.cls     = cls;
    entry_d.illegal = (cls == CLS_ILLEGAL);
    case (cls)
      CLS_ALU:            entry_d.imm = (opcode == OPC_OP_IMM) ? imm_i : 32'd0;
      CLS_JALR, CLS_LOAD: entry_d.imm = imm_i;
      CLS_STORE:          entry_d.imm = imm_s;
      CLS_BRANCH:         entry_d.imm = imm_b;
      CLS_LUI, CLS_AUIPC: entry_d.imm = imm_u;
      CLS_JAL:            entry_d.imm = imm_j;
      CLS_CSR:            entry_d.imm = {27'd0, rs1};
      CLS_BITM:           entry_d.imm = {27'd0, rs2};
      default:            entry_d.imm = 32'd0;
    endcase
    case (cls)
      CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD,
      CLS_MUL, CLS_DIV, CLS_BITM, CLS_CSR: entry_d.wren = (rd != 5'd0);
      default:                             entry_d.wren = 1'b0;
    endcase
    entry_d.rden1  = use_rs1;
    entry_d.rden2  = use_rs2;
    entry_d.waddr  = entry_d.wren  ? rd  : 5'd0;
    entry_d.raddr1 = entry_d.rden1 ? rs1 : 5'd0;
    entry_d.raddr2 = entry_d.rden2 ? rs2 : 5'd0;
  end

  // Handshake qualification and next pointer/count state; flush wins over both sides.
  always_comb begin
    enq     = in_valid && in_ready && !flush;
    deq     = out_valid && out_ready && !flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = ptr_inc(wptr_q);
      else     wptr_d = wptr_q;
      if (deq) rptr_d = ptr_inc(rptr_q);
      else     rptr_d = rptr_q;
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; never cleared because the empty-queue mask hides stale data.
  always_ff @(posedge clock) begin
    if (enq && !reset) begin
      mem_q[wptr_q] <= entry_d;
    end
  end

  // Status derived from registered state only.
  always_comb begin
    in_ready  = (count_q < CW'(DEPTH));
    out_valid = (count_q != '0);
    count     = count_q;
  end

  // Present the head entry, forced to zero while the queue is empty.
  always_comb begin
    if (out_valid) begin
      shown = mem_q[rptr_q];
    end else begin
      shown = '0;
    end
    out_pc      = shown.pc;
    out_instr   = shown.instr;
    out_imm     = shown.imm;
    out_waddr   = shown.waddr;
    out_raddr1  = shown.raddr1;
    out_raddr2  = shown.raddr2;
    out_wren    = shown.wren;
    out_rden1   = shown.rden1;
    out_rden2   = shown.rden2;
    out_class   = shown.cls;
    out_illegal = shown.illegal;
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: a pattern-table instruction model
// plus a queue-of-words occupancy model drive both a full-featured instance
// and one with the M and B extensions disabled.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [3:0] F_R  = 4'd0;  // reads rs1 and rs2
  localparam logic [3:0] F_I  = 4'd1;  // reads rs1
  localparam logic [3:0] F_S  = 4'd2;
  localparam logic [3:0] F_B  = 4'd3;
  localparam logic [3:0] F_U  = 4'd4;
  localparam logic [3:0] F_J  = 4'd5;
  localparam logic [3:0] F_N  = 4'd6;  // no registers read
  localparam logic [3:0] F_CR = 4'd7;  // csr, register source
  localparam logic [3:0] F_CI = 4'd8;  // csr, immediate source

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  cls;
    logic [3:0]  fmt;
    logic [1:0]  ext;  // 0 base, 1 needs M, 2 needs B
  } pat_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  typedef struct packed {
    logic [3:0]  cls;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wren;
    logic        rden1;
    logic        rden2;
    logic        illegal;
  } dec_t;

  logic clock = 1'b0;
  logic reset, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic a_in_ready, a_out_valid, a_wren, a_rden1, a_rden2, a_illegal;
  logic [31:0] a_pc, a_instr, a_imm;
  logic [4:0] a_waddr, a_raddr1, a_raddr2;
  logic [3:0] a_class;
  logic [CW-1:0] a_count;

  logic b_in_ready, b_out_valid, b_wren, b_rden1, b_rden2, b_illegal;
  logic [31:0] b_pc, b_instr, b_imm;
  logic [4:0] b_waddr, b_raddr1, b_raddr2;
  logic [3:0] b_class;
  logic [CW-1:0] b_count;

  pat_t  pats[$];
  item_t mq[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clock = ~clock;

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b1), .ENABLE_B(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_pc), .out_instr(a_instr), .out_imm(a_imm),
    .out_waddr(a_waddr), .out_raddr1(a_raddr1), .out_raddr2(a_raddr2),
    .out_wren(a_wren), .out_rden1(a_rden1), .out_rden2(a_rden2),
    .out_class(a_class), .out_illegal(a_illegal), .count(a_count)
  );

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b0), .ENABLE_B(1'b0)) dut_nm (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_pc), .out_instr(b_instr), .out_imm(b_imm),
    .out_waddr(b_waddr), .out_raddr1(b_raddr1), .out_raddr2(b_raddr2),
    .out_wren(b_wren), .out_rden1(b_rden1), .out_rden2(b_rden2),
    .out_class(b_class), .out_illegal(b_illegal), .count(b_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic void add_pat(input logic [31:0] mask, input logic [31:0] match,
                                  input logic [3:0] cls, input logic [3:0] fmt, input logic [1:0] ext);
    pat_t p;
    p.mask = mask; p.match = match; p.cls = cls; p.fmt = fmt; p.ext = ext;
    pats.push_back(p);
  endfunction

  // The legal RV32I/M/Zb* encodings written as mask/match rows.
  function automatic void build_table();
    logic [31:0] bf7 [7];
    logic [7:0]  bf3 [7];
    logic [31:0] unary [5];
    bf7 = '{32'h10, 32'h20, 32'h05, 32'h30, 32'h24, 32'h14, 32'h34};
    bf3 = '{8'h54, 8'hD0, 8'hFE, 8'h22, 8'h22, 8'h02, 8'h02};
    unary = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5};
    add_pat(32'h7F, 32'h37, 4'd2, F_U, 2'd0);
    add_pat(32'h7F, 32'h17, 4'd3, F_U, 2'd0);
    add_pat(32'h7F, 32'h6F, 4'd4, F_J, 2'd0);
    add_pat(32'h707F, 32'h67, 4'd5, F_I, 2'd0);
    for (int f = 0; f < 8; f++) begin
      logic [31:0] f3;
      f3 = 32'(f) << 12;
      if (f != 2 && f != 3) add_pat(32'h707F, f3 | 32'h63, 4'd6, F_B, 2'd0);
      if (f != 3 && f < 6) add_pat(32'h707F, f3 | 32'h03, 4'd7, F_I, 2'd0);
      if (f < 3) add_pat(32'h707F, f3 | 32'h23, 4'd8, F_S, 2'd0);
      if (f != 1 && f != 5) add_pat(32'h707F, f3 | 32'h13, 4'd1, F_I, 2'd0);
      add_pat(32'hFE00707F, f3 | 32'h33, 4'd1, F_R, 2'd0);
      add_pat(32'hFE00707F, f3 | 32'h02000033, (f < 4) ? 4'd9 : 4'd10, F_R, 2'd1);
      if (f < 2) add_pat(32'h707F, f3 | 32'h0F, 4'd12, F_N, 2'd0);
      if (f >= 1 && f <= 3) add_pat(32'h707F, f3 | 32'h73, 4'd13, F_CR, 2'd0);
      if (f >= 5) add_pat(32'h707F, f3 | 32'h73, 4'd13, F_CI, 2'd0);
      for (int k = 0; k < 7; k++) begin
        if (bf3[k][f]) add_pat(32'hFE00707F, (bf7[k] << 25) | f3 | 32'h33, 4'd11, F_R, 2'd2);
      end
    end
    add_pat(32'hFE00707F, 32'h00001013, 4'd1, F_I, 2'd0);
    add_pat(32'hFE00707F, 32'h00005013, 4'd1, F_I, 2'd0);
    add_pat(32'hFE00707F, 32'h40005013, 4'd1, F_I, 2'd0);
    add_pat(32'hFE00707F, 32'h40000033, 4'd1, F_R, 2'd0);
    add_pat(32'hFE00707F, 32'h40005033, 4'd1, F_R, 2'd0);
    add_pat(32'hFFF0707F, 32'h00000073, 4'd14, F_N, 2'd0);
    add_pat(32'hFFF0707F, 32'h00100073, 4'd14, F_N, 2'd0);
    add_pat(32'hFFF0707F, 32'h30200073, 4'd14, F_N, 2'd0);
    add_pat(32'hFFF0707F, 32'h10500073, 4'd14, F_N, 2'd0);
    add_pat(32'hFFF0707F, 32'h08004033, 4'd11, F_I, 2'd2);
    for (int k = 0; k < 5; k++) add_pat(32'hFFF0707F, 32'h60001013 | (unary[k] << 20), 4'd11, F_I, 2'd2);
    add_pat(32'hFE00707F, 32'h28001013, 4'd11, F_I, 2'd2);
    add_pat(32'hFE00707F, 32'h48001013, 4'd11, F_I, 2'd2);
    add_pat(32'hFE00707F, 32'h68001013, 4'd11, F_I, 2'd2);
    add_pat(32'hFE00707F, 32'h60005013, 4'd11, F_I, 2'd2);
    add_pat(32'hFE00707F, 32'h48005013, 4'd11, F_I, 2'd2);
    add_pat(32'hFFF0707F, 32'h28705013, 4'd11, F_I, 2'd2);
    add_pat(32'hFFF0707F, 32'h69805013, 4'd11, F_I, 2'd2);
  endfunction

  // Sign-extend the low b bits of v.
  function automatic logic [31:0] sext(input logic [31:0] v, input int b);
    logic [31:0] m;
    m = 32'd1 << (b - 1);
    return (v ^ m) - m;
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] w, input bit em, input bit eb);
    dec_t d;
    logic [3:0] fmt;
    logic [4:0] rd, rs1, rs2;
    d = '0;
    fmt = F_N;
    foreach (pats[k]) begin
      if (((w & pats[k].mask) == pats[k].match) &&
          (pats[k].ext == 2'd0 || (pats[k].ext == 2'd1 && em) || (pats[k].ext == 2'd2 && eb))) begin
        d.cls = pats[k].cls;
        fmt = pats[k].fmt;
      end
    end
    if (w == 32'h0000_0013) d.cls = 4'd15;
    rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20];
    d.illegal = (d.cls == 4'd0);
    d.wren  = (d.cls inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13}) && (rd != 5'd0);
    d.rden1 = !d.illegal && (fmt inside {F_R, F_I, F_S, F_B, F_CR});
    d.rden2 = !d.illegal && (fmt inside {F_R, F_S, F_B});
    d.waddr  = d.wren  ? rd  : 5'd0;
    d.raddr1 = d.rden1 ? rs1 : 5'd0;
    d.raddr2 = d.rden2 ? rs2 : 5'd0;
    case (d.cls)
      4'd1:       d.imm = (fmt == F_I) ? sext(32'(w[31:20]), 12) : 32'd0;
      4'd5, 4'd7: d.imm = sext(32'(w[31:20]), 12);
      4'd8:       d.imm = sext(32'({w[31:25], w[11:7]}), 12);
      4'd6:       d.imm = sext(32'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      4'd2, 4'd3: d.imm = w & 32'hFFFF_F000;
      4'd4:       d.imm = sext(32'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      4'd13:      d.imm = 32'(rs1);
      4'd11:      d.imm = 32'(rs2);
      default:    d.imm = 32'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    int r;
    int k;
    logic [31:0] w;
    r = $urandom_range(0, 99);
    if (r < 70) begin
      k = $urandom_range(0, pats.size() - 1);
      w = ($urandom() & ~pats[k].mask) | pats[k].match;
    end else if (r < 75) begin
      w = 32'h0000_0013;
    end else if (r < 92) begin
      w = $urandom();
      w[1:0] = 2'b11;
    end else begin
      w = $urandom();
    end
    return w;
  endfunction

  task automatic check_dut(input string p, input bit em, input bit eb, input logic [CW-1:0] cnt,
                           input logic rdy, input logic vld, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] imm, input logic [4:0] wa, input logic [4:0] r1,
                           input logic [4:0] r2, input logic we, input logic re1, input logic re2,
                           input logic [3:0] cls, input logic ill);
    dec_t e;
    logic [31:0] epc, ein;
    if (mq.size() != 0) begin
      e = ref_decode(mq[0].instr, em, eb);
      epc = mq[0].pc;
      ein = mq[0].instr;
    end else begin
      e = '0;
      epc = 32'd0;
      ein = 32'd0;
    end
    check_eq({p, "_count"}, 32'(cnt), 32'(mq.size()));
    check_eq({p, "_in_ready"}, 32'(rdy), 32'(mq.size() < DEPTH));
    check_eq({p, "_out_valid"}, 32'(vld), 32'(mq.size() != 0));
    check_eq({p, "_pc"}, pc, epc);
    check_eq({p, "_instr"}, ins, ein);
    check_eq({p, "_imm"}, imm, e.imm);
    check_eq({p, "_waddr"}, 32'(wa), 32'(e.waddr));
    check_eq({p, "_raddr1"}, 32'(r1), 32'(e.raddr1));
    check_eq({p, "_raddr2"}, 32'(r2), 32'(e.raddr2));
    check_eq({p, "_wren"}, 32'(we), 32'(e.wren));
    check_eq({p, "_rden1"}, 32'(re1), 32'(e.rden1));
    check_eq({p, "_rden2"}, 32'(re2), 32'(e.rden2));
    check_eq({p, "_class"}, 32'(cls), 32'(e.cls));
    check_eq({p, "_illegal"}, 32'(ill), 32'(e.illegal));
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare both instances.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bit acc, dq;
    item_t it;
    reset = rst; in_valid = v; in_instr = instr; in_pc = pc; out_ready = rdy; flush = fl;
    acc = v && (mq.size() < DEPTH) && !fl;
    dq  = (mq.size() != 0) && rdy && !fl;
    @(posedge clock);
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (dq) void'(mq.pop_front());
      if (acc) begin
        it.instr = instr;
        it.pc = pc;
        mq.push_back(it);
      end
    end
    #2;
    check_dut("a", 1'b1, 1'b1, a_count, a_in_ready, a_out_valid, a_pc, a_instr, a_imm, a_waddr,
              a_raddr1, a_raddr2, a_wren, a_rden1, a_rden2, a_class, a_illegal);
    check_dut("b", 1'b0, 1'b0, b_count, b_in_ready, b_out_valid, b_pc, b_instr, b_imm, b_waddr,
              b_raddr1, b_raddr2, b_wren, b_rden1, b_rden2, b_class, b_illegal);
  endtask

  initial begin
    logic [31:0] words [5];
    int rprob;
    words = '{32'h00500093, 32'h022081B3, 32'h00C12083, 32'hFE209EE3, 32'h40B50533};
    build_table();

    // Reset state
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_eq("rst_count", 32'(a_count), 32'd0);
    check_eq("rst_in_ready", 32'(a_in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);

    // addi x1,x0,5 visible one cycle after acceptance
    cycle(1'b0, 1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
    check_eq("addi_valid", 32'(a_out_valid), 32'd1);
    check_eq("addi_class", 32'(a_class), 32'd1);
    check_eq("addi_imm", a_imm, 32'd5);
    check_eq("addi_waddr", 32'(a_waddr), 32'd1);
    check_eq("addi_wren", 32'(a_wren), 32'd1);
    check_eq("addi_rden1", 32'(a_rden1), 32'd1);
    check_eq("addi_rden2", 32'(a_rden2), 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // mul with and without the M extension
    cycle(1'b0, 1'b1, 32'h022081B3, 32'h104, 1'b0, 1'b0);
    check_eq("mul_class", 32'(a_class), 32'd9);
    check_eq("mul_waddr", 32'(a_waddr), 32'd3);
    check_eq("mul_wren", 32'(a_wren), 32'd1);
    check_eq("nomul_illegal", 32'(b_illegal), 32'd1);
    check_eq("nomul_class", 32'(b_class), 32'd0);
    check_eq("nomul_wren", 32'(b_wren), 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Fill past capacity, then drain in order
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, words[i], 32'h1000 + 32'(i) * 32'd4, 1'b0, 1'b0);
    check_eq("full_count", 32'(a_count), 32'd4);
    check_eq("full_in_ready", 32'(a_in_ready), 32'd0);
    // Full queue dequeuing while offered a word must not accept it
    cycle(1'b0, 1'b1, 32'h00000013, 32'h2000, 1'b1, 1'b0);
    check_eq("full_deq_count", 32'(a_count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      check_eq("drain_pc", a_pc, 32'h1000 + 32'(i) * 32'd4);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    check_eq("drained_count", 32'(a_count), 32'd0);

    // Flush with a simultaneous offer
    cycle(1'b0, 1'b1, words[2], 32'h300, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, words[3], 32'h304, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, words[4], 32'h308, 1'b1, 1'b1);
    check_eq("flush_count", 32'(a_count), 32'd0);
    check_eq("flush_valid", 32'(a_out_valid), 32'd0);
    check_eq("flush_in_ready", 32'(a_in_ready), 32'd1);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_eq("flush_absent", 32'(a_count), 32'd0);

    // Steady enqueue+dequeue at count 2 across pointer wrap
    cycle(1'b0, 1'b1, words[0], 32'h400, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, words[1], 32'h404, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, rand_instr(), 32'h500 + 32'(i) * 32'd4, 1'b1, 1'b0);
      check_eq("stream_count", 32'(a_count), 32'd2);
    end

    // Reset overriding a non-empty queue, flush and handshakes
    cycle(1'b0, 1'b1, words[2], 32'h600, 1'b0, 1'b0);
    check_eq("pre_rst_count", 32'(a_count), 32'd3);
    cycle(1'b1, 1'b1, words[3], 32'h604, 1'b1, 1'b1);
    check_eq("rst_mid_count", 32'(a_count), 32'd0);
    check_eq("rst_mid_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_mid_class", 32'(a_class), 32'd0);
    check_eq("rst_mid_imm", a_imm, 32'd0);
    check_eq("rst_mid_pc", a_pc, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rprob = ((i / 100) % 2 == 1) ? 85 : 30;
      cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            rand_instr(), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 99) < rprob) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
